div_operand_sequencer: RTL and testbench

//   Upstream front-end for the 6-bit restoring divider. Accepts a 2W-bit dividend and a
//   W-bit divisor on a valid/ready handshake and pulses the divider's start. It then

---
 rtl/div_operand_sequencer_if.sv | 31 +++
 rtl/div_operand_sequencer.sv | 117 +++++++++++
 tb/tb_div_operand_sequencer.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/div_operand_sequencer_if.sv
// Handshake and divider-bus signal bundle for div_operand_sequencer.
// The slave modport is the sequencer's view; master is the surrounding environment.
interface div_operand_sequencer_if #(
  parameter int unsigned W = 6
) ();
  logic           in_valid;
  logic           in_ready;
  logic [2*W-1:0] in_dividend;
  logic [W-1:0]   in_divisor;
  logic           div_start;
  logic [W-1:0]   div_bus;
  logic [W-1:0]   div_q;
  logic [W-1:0]   div_r;
  logic           div_done;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   out_q;
  logic [W-1:0]   out_r;
  logic [1:0]     out_err;
  logic           busy;

  modport slave (
    input  in_valid, in_dividend, in_divisor, div_q, div_r, div_done, out_ready,
    output in_ready, div_start, div_bus, out_valid, out_q, out_r, out_err, busy
  );

  modport master (
    output in_valid, in_dividend, in_divisor, div_q, div_r, div_done, out_ready,
    input  in_ready, div_start, div_bus, out_valid, out_q, out_r, out_err, busy
  );
endinterface

// File: rtl/div_operand_sequencer.sv
// Front-end for the restoring divider: accepts operands, traps zero/overflow cases, serializes
// the operands onto the shared divider bus, waits for done and holds the result for downstream.
module div_operand_sequencer #(
  parameter int unsigned W       = 6,
  parameter int unsigned TIMEOUT = 64
) (
  input logic                   clk,
  input logic                   rst,
  div_operand_sequencer_if.slave bus
);

  localparam int unsigned TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {
    StIdle, StStart, StHi, StLo, StDiv, StWait, StResp
  } state_e;

  state_e         state_q, state_d;
  logic [2*W-1:0] a_q;
  logic [W-1:0]   b_q;
  logic [W-1:0]   q_q;
  logic [W-1:0]   r_q;
  logic [1:0]     err_q;
  logic           done_d;
  logic [TW-1:0]  timer_q;

  logic accept, div_zero, overflow, done_rise, timeout;

  assign accept    = bus.in_valid && (state_q == StIdle);
  assign div_zero  = (bus.in_divisor == '0);
  // Quotient fits W bits only when the dividend's upper slice is below the divisor.
  assign overflow  = (bus.in_dividend[2*W-1:W] >= bus.in_divisor);
  // Edge detect so a done level left over from a prior operation is ignored.
  assign done_rise = bus.div_done && !done_d;
  assign timeout   = (timer_q == TW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = (div_zero || overflow) ? StResp : StStart;
      StStart: state_d = StHi;
      StHi:    state_d = StLo;
      StLo:    state_d = StDiv;
      StDiv:   state_d = StWait;
      StWait:  if (done_rise || timeout) state_d = StResp;
      StResp:  if (bus.out_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    bus.in_ready  = (state_q == StIdle);
    bus.busy      = (state_q != StIdle);
    bus.div_start = (state_q == StStart);
    bus.out_valid = (state_q == StResp);
    bus.out_q     = q_q;
    bus.out_r     = r_q;
    bus.out_err   = err_q;
    unique case (state_q)
      StHi:    bus.div_bus = a_q[2*W-1:W];
      StLo:    bus.div_bus = a_q[W-1:0];
      StDiv:   bus.div_bus = b_q;
      default: bus.div_bus = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_q     <= '0;
      b_q     <= '0;
      q_q     <= '0;
      r_q     <= '0;
      err_q   <= 2'b00;
      done_d  <= 1'b0;
      timer_q <= '0;
    end else begin
      done_d <= bus.div_done;
      if (accept) begin
        a_q <= bus.in_dividend;
        b_q <= bus.in_divisor;
        if (div_zero) begin
          q_q   <= '0;
          r_q   <= '0;
          err_q <= 2'b01;
        end else if (overflow) begin
          q_q   <= '0;
          r_q   <= '0;
          err_q <= 2'b10;
        end
      end
      if (state_q == StDiv) begin
        timer_q <= '0;
      end
      if (state_q == StWait) begin
        timer_q <= timer_q + 1'b1;
        if (done_rise) begin
          q_q   <= bus.div_q;
          r_q   <= bus.div_r;
          err_q <= 2'b00;
        end else if (timeout) begin
          q_q   <= '0;
          r_q   <= '0;
          err_q <= 2'b11;
        end
      end
    end
  end

endmodule

// File: tb/tb_div_operand_sequencer.sv
// Bench for div_operand_sequencer: divider model driven from the serialized bus, table vectors,
// randomized operands against an arithmetic reference, and hand-written corner sequences.
module tb_div_operand_sequencer;

  localparam int W       = 6;
  localparam int TIMEOUT = 64;
  localparam int N_DONE  = 20;

  logic clk;
  logic rst;

  div_operand_sequencer_if #(.W(W)) sif ();

  div_operand_sequencer #(.W(W), .TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (sif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_fail = 0;

  // Divider model: 0 = done pulse N_DONE cycles after start, 1 = never done, 2 = done held high.
  int         mode = 0;
  int         since;
  logic [5:0] cap_hi, cap_lo, cap_b;
  logic       done_m;
  logic [5:0] q_m, r_m;

  assign sif.div_done = done_m;
  assign sif.div_q    = q_m;
  assign sif.div_r    = r_m;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      since  <= -1;
      done_m <= 1'b0;
      q_m    <= '0;
      r_m    <= '0;
      cap_hi <= '0;
      cap_lo <= '0;
      cap_b  <= '0;
    end else begin
      if (sif.div_start) since <= 0;
      else if (since >= 0 && since < 10000) since <= since + 1;
      if (since == 0) cap_hi <= sif.div_bus;
      if (since == 1) cap_lo <= sif.div_bus;
      if (since == 2) cap_b  <= sif.div_bus;
      if (mode == 2) begin
        done_m <= 1'b1;
      end else if (mode == 0 && since == N_DONE - 1) begin
        done_m <= 1'b1;
        if (cap_b != 0) begin
          q_m <= 6'(int'({cap_hi, cap_lo}) / int'(cap_b));
          r_m <= 6'(int'({cap_hi, cap_lo}) % int'(cap_b));
        end
      end else begin
        done_m <= 1'b0;
      end
    end
  end

  task automatic check(input string name, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic fail_bound(input string name);
    n_vec++;
    n_fail++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  // Reference: quotient must fit W bits, otherwise the operands are trapped.
  task automatic ref_div(input int a, input int b, output int q, output int r, output int e);
    q = 0; r = 0;
    if (b == 0) e = 1;
    else if (a / b > 63) e = 2;
    else begin
      e = 0; q = a / b; r = a % b;
    end
  endtask

  logic [5:0] bus_seen [1:4];

  // Called and returning at a negedge; returns on the negedge where out_valid is first seen.
  task automatic do_op(input int a, input int b, output int q, output int r, output int e,
                       output int lat, output int starts, output int start_at);
    int guard;
    guard = 0;
    while (!sif.in_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) fail_bound("in_ready");
    sif.in_valid    = 1'b1;
    sif.in_dividend = 12'(a);
    sif.in_divisor  = 6'(b);
    @(negedge clk);
    sif.in_valid = 1'b0;
    lat = 1; starts = 0; start_at = -1;
    for (int i = 1; i <= 4; i++) bus_seen[i] = 6'h3f;
    while (!sif.out_valid && lat < 300) begin
      if (sif.div_start) begin
        starts++;
        start_at = lat;
      end
      if (lat <= 4) bus_seen[lat] = sif.div_bus;
      @(negedge clk);
      lat++;
    end
    if (!sif.out_valid) fail_bound("out_valid");
    q = int'(sif.out_q);
    r = int'(sif.out_r);
    e = int'(sif.out_err);
  endtask

  task automatic check_op(input string tag, input int a, input int b, input bit force_to);
    int eq, er, ee, q, r, e, lat, starts, start_at;
    ref_div(a, b, eq, er, ee);
    if (force_to && ee == 0) begin
      eq = 0; er = 0; ee = 3;
    end
    do_op(a, b, q, r, e, lat, starts, start_at);
    check({tag, " q"}, q, eq);
    check({tag, " r"}, r, er);
    check({tag, " err"}, e, ee);
    check({tag, " starts"}, starts, (ee == 0 || ee == 3) ? 1 : 0);
    if (ee == 0 || ee == 3) begin
      check({tag, " start_at"}, start_at, 1);
      check({tag, " bus start"}, int'(bus_seen[1]), 0);
      check({tag, " bus hi"}, int'(bus_seen[2]), a / 64);
      check({tag, " bus lo"}, int'(bus_seen[3]), a % 64);
      check({tag, " bus div"}, int'(bus_seen[4]), b);
    end else begin
      check({tag, " trap latency"}, lat, 1);
    end
    if (ee == 3) check({tag, " timeout latency"}, lat, 4 + TIMEOUT + 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " in_ready"}, int'(sif.in_ready), 1);
    check({tag, " div_start"}, int'(sif.div_start), 0);
    check({tag, " div_bus"}, int'(sif.div_bus), 0);
    check({tag, " out_valid"}, int'(sif.out_valid), 0);
    check({tag, " out_q"}, int'(sif.out_q), 0);
    check({tag, " out_r"}, int'(sif.out_r), 0);
    check({tag, " out_err"}, int'(sif.out_err), 0);
    check({tag, " busy"}, int'(sif.busy), 0);
  endtask

  typedef struct {
    int a;
    int b;
    int q;
    int r;
    int e;
  } vec_t;

  vec_t vecs [7];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int q, r, e, lat, starts, start_at, a, b, sel;

    vecs[0] = '{678, 20, 33, 18, 0};
    vecs[1] = '{593, 31, 19, 4, 0};
    vecs[2] = '{822, 15, 54, 12, 0};
    vecs[3] = '{976, 26, 37, 14, 0};
    vecs[4] = '{678, 0, 0, 0, 1};
    vecs[5] = '{1357, 20, 0, 0, 2};
    vecs[6] = '{1357, 22, 61, 15, 0};

    rst             = 1'b0;
    sif.in_valid    = 1'b0;
    sif.in_dividend = '0;
    sif.in_divisor  = '0;
    sif.out_ready   = 1'b1;
    #1;
    check_reset_outputs("reset");
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Table vectors, back to back with out_ready held high.
    foreach (vecs[i]) begin
      do_op(vecs[i].a, vecs[i].b, q, r, e, lat, starts, start_at);
      check($sformatf("vec%0d q", i), q, vecs[i].q);
      check($sformatf("vec%0d r", i), r, vecs[i].r);
      check($sformatf("vec%0d err", i), e, vecs[i].e);
      check($sformatf("vec%0d starts", i), starts, (vecs[i].e == 0) ? 1 : 0);
      if (vecs[i].e == 0) begin
        check($sformatf("vec%0d bus hi", i), int'(bus_seen[2]), vecs[i].a / 64);
        check($sformatf("vec%0d bus lo", i), int'(bus_seen[3]), vecs[i].a % 64);
        check($sformatf("vec%0d bus div", i), int'(bus_seen[4]), vecs[i].b);
      end else begin
        check($sformatf("vec%0d trap latency", i), lat, 1);
      end
    end

    // Spec scenario 1 with full bus sequence check.
    check_op("678/20", 678, 20, 1'b0);

    // Timeout: divider never answers, then divider done stuck high.
    mode = 1;
    check_op("never done", 678, 20, 1'b1);
    mode = 2;
    @(negedge clk);
    check_op("done stuck", 593, 31, 1'b1);
    mode = 0;
    @(negedge clk);

    // Downstream stall for 5 cycles.
    sif.out_ready = 1'b0;
    do_op(678, 20, q, r, e, lat, starts, start_at);
    check("stall first q", q, 33);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("stall out_valid", int'(sif.out_valid), 1);
      check("stall in_ready", int'(sif.in_ready), 0);
      check("stall out_q", int'(sif.out_q), 33);
      check("stall out_r", int'(sif.out_r), 18);
      check("stall out_err", int'(sif.out_err), 0);
    end
    sif.out_ready = 1'b1;
    @(negedge clk);
    check("stall release out_valid", int'(sif.out_valid), 0);
    check("stall release in_ready", int'(sif.in_ready), 1);

    // Reset while waiting on the divider.
    sif.in_valid    = 1'b1;
    sif.in_dividend = 12'd976;
    sif.in_divisor  = 6'd26;
    @(negedge clk);
    sif.in_valid = 1'b0;
    repeat (8) @(negedge clk);
    check("pre-reset busy", int'(sif.busy), 1);
    rst = 1'b0;
    #1;
    check_reset_outputs("mid reset");
    @(negedge clk);
    rst = 1'b1;
    starts = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (sif.div_start || sif.out_valid) starts++;
    end
    check("post-reset activity", starts, 0);
    check_op("post-reset 678/20", 678, 20, 1'b0);

    // Randomized operands against the arithmetic reference.
    for (int n = 0; n < 40; n++) begin
      sel = int'($urandom_range(0, 9));
      if (sel == 0) begin
        b = 0;
        a = int'($urandom_range(0, 4095));
      end else begin
        b = int'($urandom_range(1, 63));
        if (sel == 1) a = int'($urandom_range(0, 4095));
        else a = int'($urandom_range(0, b * 64 - 1));
      end
      check_op($sformatf("rand%0d %0d/%0d", n, a, b), a, b, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
